obi_to_axi_lite_master: RTL and testbench

- Converts the eros_top external OBI manager port (ext_slave_req_o / ext_slave_resp_i) into an AXI4-Lite manager.
- This is the outbound counterpart of the inbound AXI to AXI-Lite to APB to OBI path.
- Single outstanding transaction. Registered, protocol-compliant AXI valids. Captures the response for OBI rvalid.
- Sits between eros_top and the SoC AXI-Lite interconnect, on the gated-clock domain.

---
 rtl/obi_to_axi_lite_master.sv | 189 ++++++++++++++++++
 tb/tb_obi_to_axi_lite_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_to_axi_lite_master.sv
// Bridges an OBI manager port onto an AXI4-Lite manager, one transaction at a time.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   obi_req_i/obi_gnt_o      OBI address phase (grant is combinational)
//   obi_addr_i/we_i/be_i/wdata_i  OBI request payload
//   obi_rvalid_o/rdata_o/err_o    OBI response (one-cycle pulse)
//   m_aw*/m_w*/m_b*          AXI-Lite write channels
//   m_ar*/m_r*               AXI-Lite read channels
//   busy_o                   transaction in flight
//   err_cnt_o                saturating count of non-OKAY responses
module obi_to_axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o,
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic [2:0]              m_awprot_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  input  logic [1:0]              m_bresp_i,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o,
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic [2:0]              m_arprot_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]              m_rresp_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  output logic                    busy_o,
  output logic [7:0]              err_cnt_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_RSP = 3'd2,
    RD_REQ = 3'd3,
    RD_RSP = 3'd4,
    RSP    = 3'd5
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   be_q;
  logic                    awvalid_q, wvalid_q, aw_done_q, w_done_q;
  logic                    bready_q, arvalid_q, rready_q;
  logic                    rvalid_q, err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [7:0]              err_cnt_q;

  logic aw_hs, w_hs, b_err, r_err, cnt_sat;

  assign aw_hs   = awvalid_q & m_awready_i;
  assign w_hs    = wvalid_q & m_wready_i;
  assign b_err   = (m_bresp_i != 2'b00);
  assign r_err   = (m_rresp_i != 2'b00);
  assign cnt_sat = (err_cnt_q == 8'hFF);

  // Grant only while idle; this is what enforces a single outstanding transaction.
  assign obi_gnt_o = obi_req_i & (state_q == IDLE);

  // Transaction FSM with all AXI/OBI handshake outputs held in registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= 8'h00;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (obi_req_i) begin
            addr_q  <= obi_addr_i;
            wdata_q <= obi_wdata_i;
            be_q    <= obi_be_i;
            if (obi_we_i) begin
              state_q   <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              state_q   <= RD_REQ;
              arvalid_q <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          // AW and W retire independently; leave once both have been accepted.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
            state_q  <= WR_RSP;
            bready_q <= 1'b1;
          end
        end
        WR_RSP: begin
          if (m_bvalid_i) begin
            bready_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= b_err;
            rvalid_q <= 1'b1;
            state_q  <= RSP;
            if (b_err && !cnt_sat) err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
        RD_REQ: begin
          if (m_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RSP;
          end
        end
        RD_RSP: begin
          if (m_rvalid_i) begin
            rready_q <= 1'b0;
            rdata_q  <= m_rdata_i;
            err_q    <= r_err;
            rvalid_q <= 1'b1;
            state_q  <= RSP;
            if (r_err && !cnt_sat) err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
        RSP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;
  assign m_awaddr_o   = addr_q;
  assign m_awprot_o   = AXI_PROT;
  assign m_awvalid_o  = awvalid_q;
  assign m_wdata_o    = wdata_q;
  assign m_wstrb_o    = be_q;
  assign m_wvalid_o   = wvalid_q;
  assign m_bready_o   = bready_q;
  assign m_araddr_o   = addr_q;
  assign m_arprot_o   = AXI_PROT;
  assign m_arvalid_o  = arvalid_q;
  assign m_rready_o   = rready_q;
  assign busy_o       = (state_q != IDLE);
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_obi_to_axi_lite_master.sv
// Scoreboard bench for obi_to_axi_lite_master: a directed driver pushes the
// expected OBI response, a responder plays the AXI-Lite subordinate, and a
// monitor pops/compares on every obi_rvalid_o.
module tb_obi_to_axi_lite_master;

  logic        clk, rst;
  logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_err;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic [3:0]  obi_be;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic        busy;
  logic [7:0]  err_cnt;

  obi_to_axi_lite_master dut (
    .clk_i(clk), .rst_i(rst),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr),
    .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
    .obi_rvalid_o(obi_rvalid), .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
    .m_awaddr_o(m_awaddr), .m_awprot_o(m_awprot), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
    .m_araddr_o(m_araddr), .m_arprot_o(m_arprot), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
    .busy_o(busy), .err_cnt_o(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard entries are {rdata, err}.
  logic [32:0] exp_q[$];
  int          n_exp = 0;
  int          rv_count = 0;
  int          t_rv = -1;

  // Subordinate configuration and expected AXI request fields.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  logic [31:0] exp_aw_addr, exp_wdata, exp_ar_addr;
  logic [3:0]  exp_wstrb;
  int          aw_cycles = 0, w_cycles = 0;

  // AXI-Lite subordinate: readies after a programmable delay, B/R one cycle after request accept.
  initial begin
    int   aw_cnt, w_cnt, ar_cnt;
    logic pend_aw, pend_w, pend_ar, pend_b, pend_r;
    logic aw_done, w_done, ar_done;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    pend_aw = 0; pend_w = 0; pend_ar = 0; pend_b = 0; pend_r = 0;
    aw_done = 0; w_done = 0; ar_done = 0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bresp = 2'b00; m_rvalid = 0; m_rresp = 2'b00; m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        pend_aw = 0; pend_w = 0; pend_ar = 0; pend_b = 0; pend_r = 0;
        aw_done = 0; w_done = 0; ar_done = 0;
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
      end else begin
        if (pend_aw) aw_done = 1;
        if (pend_w)  w_done  = 1;
        if (pend_ar) ar_done = 1;
        if (pend_b)  m_bvalid = 0;
        if (pend_r)  m_rvalid = 0;
        if (m_awvalid) begin
          aw_cycles++;
          chk("awaddr", 64'(m_awaddr), 64'(exp_aw_addr));
          chk("awprot", 64'(m_awprot), 64'(3'b000));
          m_awready = (aw_cnt >= aw_delay);
          aw_cnt++;
        end else begin
          m_awready = 0; aw_cnt = 0;
        end
        if (m_wvalid) begin
          w_cycles++;
          chk("wdata", 64'(m_wdata), 64'(exp_wdata));
          chk("wstrb", 64'(m_wstrb), 64'(exp_wstrb));
          m_wready = (w_cnt >= w_delay);
          w_cnt++;
        end else begin
          m_wready = 0; w_cnt = 0;
        end
        if (m_arvalid) begin
          chk("araddr", 64'(m_araddr), 64'(exp_ar_addr));
          chk("arprot", 64'(m_arprot), 64'(3'b000));
          m_arready = (ar_cnt >= ar_delay);
          ar_cnt++;
        end else begin
          m_arready = 0; ar_cnt = 0;
        end
        if (aw_done && w_done && !m_bvalid) begin
          m_bvalid = 1; m_bresp = b_resp_cfg; aw_done = 0; w_done = 0;
        end
        if (ar_done && !m_rvalid) begin
          m_rvalid = 1; m_rdata = r_data_cfg; m_rresp = r_resp_cfg; ar_done = 0;
        end
        pend_aw = m_awvalid && m_awready;
        pend_w  = m_wvalid && m_wready;
        pend_ar = m_arvalid && m_arready;
        pend_b  = m_bvalid && m_bready;
        pend_r  = m_rvalid && m_rready;
      end
    end
  end

  // Monitor: pop and compare on each OBI response; check cross-channel invariants.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk); #2;
      if (!rst && obi_rvalid) begin
        rv_count++;
        t_rv = cyc;
        chk("rvalid_busy", 64'(busy), 64'(1'b1));
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rvalid_unexpected: got rvalid with rdata 0x%0h, expected no response", obi_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", 64'(obi_rdata), 64'(e[32:1]));
          chk("err", 64'(obi_err), 64'(e[0]));
        end
      end
      if (obi_gnt) chk("gnt_busy", 64'(busy), 64'(1'b0));
      if (m_awvalid || m_wvalid || m_arvalid)
        chk("no_overlap", 64'(m_arvalid && (m_awvalid || m_wvalid)), 64'(1'b0));
    end
  end

  // Present one OBI request and wait (bounded) for its grant; t_g is the grant cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                       input logic keep_req, output int t_g);
    obi_req = 1; obi_we = we; obi_addr = addr; obi_wdata = wd; obi_be = be;
    if (we) begin
      exp_aw_addr = addr; exp_wdata = wd; exp_wstrb = be;
    end else begin
      exp_ar_addr = addr;
    end
    exp_q.push_back({exp_rd, exp_err});
    n_exp++;
    t_g = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (obi_gnt) begin
        t_g = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t_g < 0) begin
      tests++; fails++;
      $display("FAIL gnt_timeout: got no grant for addr 0x%0h, expected a grant", addr);
    end
    @(negedge clk);
    if (!keep_req) obi_req = 0;
  endtask

  task automatic wait_rv();
    int ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #3;
      if (rv_count >= n_exp) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      tests++; fails++;
      $display("FAIL rvalid_timeout: got %0d responses, expected %0d", rv_count, n_exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_g, t_g2, t_rv1, c0;
    rst = 1; obi_req = 0; obi_we = 0; obi_addr = 0; obi_wdata = 0; obi_be = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_gnt", 64'(obi_gnt), 64'(1'b0));
    chk("rst_awvalid", 64'(m_awvalid), 64'(1'b0));
    chk("rst_rvalid", 64'(obi_rvalid), 64'(1'b0));
    chk("rst_rdata", 64'(obi_rdata), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    @(negedge clk);
    rst = 0;

    // Zero-wait write: response three cycles after grant.
    aw_cycles = 0; w_cycles = 0;
    issue(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0, t_g);
    wait_rv();
    chk("wr0_latency", 64'(t_rv - t_g), 64'(3));
    chk("wr0_aw_cycles", 64'(aw_cycles), 64'(1));
    chk("wr0_w_cycles", 64'(w_cycles), 64'(1));

    // Skewed write: AW accepted three cycles late, W immediately.
    aw_delay = 3; aw_cycles = 0; w_cycles = 0;
    issue(1'b1, 32'h2000_0020, 32'h0102_0304, 4'h5, 32'h0, 1'b0, 1'b0, t_g);
    wait_rv();
    chk("wr1_aw_cycles", 64'(aw_cycles), 64'(4));
    chk("wr1_w_cycles", 64'(w_cycles), 64'(1));
    chk("wr1_latency", 64'(t_rv - t_g), 64'(6));
    aw_delay = 0;

    // Read with SLVERR after a two-cycle AR stall.
    ar_delay = 2; r_data_cfg = 32'h1234_5678; r_resp_cfg = 2'b10;
    chk("rd_err_cnt_before", 64'(err_cnt), 64'(0));
    issue(1'b0, 32'h1000_0004, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 1'b0, t_g);
    wait_rv();
    chk("rd_err_cnt_after", 64'(err_cnt), 64'(1));
    ar_delay = 0;

    // Back-to-back with req held: second grant the cycle after the first rvalid.
    r_data_cfg = 32'hA5A5_0F0F; r_resp_cfg = 2'b00;
    issue(1'b1, 32'h2000_0040, 32'h5555_AAAA, 4'hC, 32'h0, 1'b0, 1'b1, t_g);
    issue(1'b0, 32'h1000_0040, 32'h0, 4'h0, 32'hA5A5_0F0F, 1'b0, 1'b0, t_g2);
    t_rv1 = t_rv;
    chk("b2b_first_rsp", 64'(t_rv1 - t_g), 64'(3));
    chk("b2b_second_gnt", 64'(t_g2 - t_rv1), 64'(1));
    wait_rv();

    // Write with no byte enables, SLVERR on B.
    b_resp_cfg = 2'b10;
    issue(1'b1, 32'h3000_0000, 32'h0000_0000, 4'h0, 32'h0, 1'b1, 1'b0, t_g);
    wait_rv();
    chk("be0_err_cnt", 64'(err_cnt), 64'(2));
    b_resp_cfg = 2'b00;

    // Saturation: 260 DECERR reads.
    r_resp_cfg = 2'b11;
    for (int i = 0; i < 260; i++) begin
      r_data_cfg = 32'hC0DE_0000 + 32'(i);
      issue(1'b0, 32'h1000_0100 + 32'(i * 4), 32'h0, 4'h0, 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0, t_g);
      wait_rv();
      if (i == 9)   chk("sat_cnt_10", 64'(err_cnt), 64'(12));
      if (i == 252) chk("sat_cnt_253", 64'(err_cnt), 64'(255));
    end
    chk("sat_cnt_final", 64'(err_cnt), 64'(8'hFF));
    r_resp_cfg = 2'b00;

    // Reset while AW is pending, then an immediate fresh request.
    aw_delay = 10;
    issue(1'b1, 32'h2000_0080, 32'h1111_2222, 4'hF, 32'h0, 1'b0, 1'b0, t_g);
    #2;
    chk("rst_mid_awvalid_pre", 64'(m_awvalid), 64'(1'b1));
    rst = 1;
    @(negedge clk); #2;
    chk("rst_mid_awvalid", 64'(m_awvalid), 64'(1'b0));
    chk("rst_mid_wvalid", 64'(m_wvalid), 64'(1'b0));
    chk("rst_mid_bready", 64'(m_bready), 64'(1'b0));
    chk("rst_mid_busy", 64'(busy), 64'(1'b0));
    chk("rst_mid_err_cnt", 64'(err_cnt), 64'(0));
    rst = 0;
    void'(exp_q.pop_back());
    n_exp--;
    rv_count = n_exp;
    aw_delay = 0;
    r_data_cfg = 32'h0BAD_F00D;
    c0 = cyc;
    issue(1'b0, 32'h4000_0008, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0, t_g);
    chk("post_rst_gnt_cycle", 64'(t_g - c0), 64'(0));
    wait_rv();
    chk("post_rst_err_cnt", 64'(err_cnt), 64'(0));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
